// File: rtl/chess_pkg.sv
// Shared chess encodings and move-generation controller constants.
// Imported by the move-generation sequencer and its cell selector.
package chess_pkg;

  localparam int NSQ       = 64;
  localparam int MOVE_W    = 19;
  localparam int SLOTS     = 8;
  localparam int WORD_W    = 160;
  localparam int CLR_CYC   = 2;
  localparam int TIMEOUT   = 255;
  localparam int SLOT_BITS = SLOTS * MOVE_W;

  // Terminal counter values, pre-sized to the registers that compare against them.
  localparam logic [7:0] CLR_LAST = 8'(CLR_CYC - 1);
  localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] SLOT_TOP = 3'(SLOTS - 1);

  typedef enum logic [2:0] {EMPTY, PAWN, KNIGHT, BISHOP, ROOK, QUEEN, KING} piece_e;
  typedef enum logic {WHITE, BLACK} color_e;

  localparam int MV_TO_LSB   = 0;
  localparam int MV_FROM_LSB = 6;
  localparam int MV_FLAG_LSB = 12;

  localparam int F_CAPTURE = 12;
  localparam int F_CASTLE  = 13;
  localparam int F_EP      = 14;
  localparam int F_PAWN2   = 15;
  localparam int F_PAWN    = 16;
  localparam int F_PROMOTE = 17;
  localparam int F_INVALID = 18;

  localparam logic [MOVE_W-1:0] IMOV = MOVE_W'(1) << F_INVALID;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RUN, S_SCAN, S_READ, S_CAPT, S_EMIT, S_FIN, S_ERR
  } state_e;

endpackage

// File: rtl/move_gen_ctrl_sq_select.sv
// Finds the lowest requesting cell at or above a scan pointer.
// Purely combinational; the caller registers the result.
module sq_select
  import chess_pkg::*;
(
  input  logic [NSQ-1:0] req_i,
  input  logic [5:0]     ptr_i,
  output logic [5:0]     idx_o,
  output logic           found_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Walking downward lets the lowest qualifying index win the last assignment.
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (req_i[i] && (6'(i) >= ptr_i)) begin
        idx_o   = 6'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_gen_ctrl.sv
// Sequences one move-generation pass: clear cells, wait for completion,
// then drain every cell FIFO in index order into a back-pressured move stream.
module move_gen_ctrl
  import chess_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [NSQ-1:0]        sq_done,
  input  logic [NSQ-1:0]        sq_empty,
  input  logic [NSQ*WORD_W-1:0] sq_q,
  output logic                  unit_reset,
  output logic [NSQ-1:0]        sq_rden,
  output logic                  mv_valid,
  output logic [MOVE_W-1:0]     mv_data,
  input  logic                  mv_ready,
  output logic                  busy,
  output logic                  gen_done,
  output logic                  err,
  output logic [7:0]            move_count
);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [5:0]           scan_ptr_q, scan_ptr_d;
  logic [2:0]           slot_q, slot_d;
  logic [SLOT_BITS-1:0] word_q, word_d;
  logic [7:0]           move_count_q, move_count_d;
  logic                 unit_reset_q;

  logic [5:0]           sel_idx;
  logic                 sel_found;
  logic [SLOT_BITS-1:0] cell_word;
  logic [MOVE_W-1:0]    slot_mv;
  logic                 slot_invalid;

  sq_select u_sel (
    .req_i   (~sq_empty),
    .ptr_i   (scan_ptr_q),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  assign cell_word    = sq_q[scan_ptr_q*WORD_W +: SLOT_BITS];
  assign slot_mv      = word_q[slot_q*MOVE_W +: MOVE_W];
  assign slot_invalid = slot_mv[F_INVALID];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scan_ptr_d   = scan_ptr_q;
    slot_d       = slot_q;
    word_d       = word_q;
    move_count_d = move_count_q;
    unique case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          state_d      = S_CLR;
          cnt_d        = '0;
          scan_ptr_d   = '0;
          move_count_d = '0;
        end
      end
      S_CLR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        // Completion wins over a timeout landing on the same cycle.
        if (&sq_done)              state_d = S_SCAN;
        else if (cnt_q == RUN_LAST) state_d = S_ERR;
        else                       cnt_d   = cnt_q + 8'd1;
      end
      S_SCAN: begin
        if (sel_found) begin
          state_d    = S_READ;
          scan_ptr_d = sel_idx;
        end else begin
          state_d = S_FIN;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        word_d  = cell_word;
        slot_d  = SLOT_TOP;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (slot_invalid || mv_ready) begin
          if (!slot_invalid && (move_count_q != 8'hFF)) move_count_d = move_count_q + 8'd1;
          if (slot_q == 3'd0) state_d = S_SCAN;
          else                slot_d  = slot_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      scan_ptr_q   <= '0;
      slot_q       <= '0;
      // NOTE: the captured word is reset too, so mv_data cannot leak a stale move after reset.
      word_q       <= '0;
      move_count_q <= '0;
      unit_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_ptr_q   <= scan_ptr_d;
      slot_q       <= slot_d;
      word_q       <= word_d;
      move_count_q <= move_count_d;
      unit_reset_q <= (state_d == S_CLR);
    end
  end

  // Outputs decode registered state only; mv_valid never sees mv_ready.
  assign unit_reset = unit_reset_q;
  assign sq_rden    = (state_q == S_READ) ? ({{(NSQ-1){1'b0}}, 1'b1} << scan_ptr_q) : '0;
  assign mv_valid   = (state_q == S_EMIT) && !slot_invalid;
  assign mv_data    = mv_valid ? slot_mv : '0;
  assign busy       = !((state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_ERR));
  assign gen_done   = (state_q == S_FIN);
  assign err        = (state_q == S_ERR);
  assign move_count = move_count_q;

endmodule

// File: tb/tb_move_gen_ctrl.sv
// Self-checking bench for move_gen_ctrl: emulated cell FIFOs, a random-ready
// consumer and a scan-order reference model of the expected move stream.
module tb_move_gen_ctrl;
  import chess_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n, start, mv_ready;
  logic [NSQ-1:0]        sq_done, sq_rden;
  logic [NSQ-1:0]        sq_empty = '1;
  logic [NSQ*WORD_W-1:0] sq_q;
  logic                  unit_reset, mv_valid, busy, gen_done, err;
  logic [MOVE_W-1:0]     mv_data;
  logic [7:0]            move_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  move_gen_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .sq_done    (sq_done),
    .sq_empty   (sq_empty),
    .sq_q       (sq_q),
    .unit_reset (unit_reset),
    .sq_rden    (sq_rden),
    .mv_valid   (mv_valid),
    .mv_data    (mv_data),
    .mv_ready   (mv_ready),
    .busy       (busy),
    .gen_done   (gen_done),
    .err        (err),
    .move_count (move_count)
  );

  // Cell contents: up to 4 words per cell, consumed from rd[c] to cnt[c]-1.
  logic [SLOT_BITS-1:0] mem [NSQ][4];
  int                   cnt [NSQ];
  int                   rd  [NSQ];
  logic [MOVE_W-1:0]    exp_q [$];
  logic [NSQ-1:0]       done_mask = '1;
  int done_cnt = 0, urst_cnt = 0, rden_n = 0, acc_n = 0, ready_pct = 100, stall_left = 0;
  int words_total = 0;
  bit                   pend_vld = 1'b0, prev_stall = 1'b0;
  int                   pend_c = 0, env_c = 0;
  logic [SLOT_BITS-1:0] pend_w;
  logic [MOVE_W-1:0]    prev_data;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_cells();
    for (int c = 0; c < NSQ; c++) begin
      cnt[c] = 0;
      rd[c]  = 0;
    end
  endtask

  task automatic add_word(input int c, input logic [SLOT_BITS-1:0] w);
    if (cnt[c] < 4) begin
      mem[c][cnt[c]] = w;
      cnt[c]++;
    end
  endtask

  function automatic logic [SLOT_BITS-1:0] rand_word(input int valid_pct);
    logic [SLOT_BITS-1:0] w;
    for (int s = 0; s < SLOTS; s++)
      w[s*MOVE_W +: MOVE_W] = {($urandom_range(99) >= valid_pct), 18'($urandom)};
    return w;
  endfunction

  // Reference stream: cells ascending, words in FIFO order, slots MSB first, invalid ones dropped.
  task automatic build_expected();
    logic [MOVE_W-1:0] m;
    exp_q.delete();
    words_total = 0;
    for (int c = 0; c < NSQ; c++)
      for (int k = rd[c]; k < cnt[c]; k++) begin
        words_total++;
        for (int s = SLOTS - 1; s >= 0; s--) begin
          m = mem[c][k][s*MOVE_W +: MOVE_W];
          if (!m[MOVE_W-1]) exp_q.push_back(m);
        end
      end
  endtask

  // Environment: cell done/FIFO emulation and the move consumer, all on the falling edge.
  initial begin
    sq_done  = '0;
    mv_ready = 1'b0;
    for (int j = 0; j < NSQ*WORD_W/32; j++) sq_q[j*32 +: 32] = $urandom;
    forever begin
      @(negedge clk);
      if (unit_reset) begin
        done_cnt = 0;
        sq_done  = '0;
        urst_cnt++;
      end else if (done_cnt < 3) done_cnt++;
      else sq_done = done_mask;

      if (pend_vld) begin
        sq_q[pend_c*WORD_W +: WORD_W] = {8'($urandom), pend_w};
        pend_vld = 1'b0;
      end
      if (sq_rden != '0) begin
        rden_n++;
        check("rden_onehot", $countones(sq_rden), 1);
        for (int i = 0; i < NSQ; i++) if (sq_rden[i]) env_c = i;
        check("rden_nonempty", rd[env_c] < cnt[env_c], 1);
        if (rd[env_c] < cnt[env_c]) begin
          pend_w   = mem[env_c][rd[env_c]];
          pend_c   = env_c;
          pend_vld = 1'b1;
          rd[env_c]++;
        end
      end
      for (int i = 0; i < NSQ; i++) sq_empty[i] = (rd[i] >= cnt[i]);

      if (reset_n) begin
        if (prev_stall) begin
          check("hold_valid", mv_valid, 1);
          check("hold_data", mv_data, prev_data);
        end
        if (stall_left > 0 && mv_valid) begin
          mv_ready = 1'b0;
          stall_left--;
        end else begin
          mv_ready = ($urandom_range(99) < ready_pct);
        end
        if (mv_valid && mv_ready) begin
          acc_n++;
          check("move_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("mv_data", mv_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        prev_stall = mv_valid && !mv_ready;
        prev_data  = mv_data;
      end else begin
        prev_stall = 1'b0;
        mv_ready   = 1'b0;
      end
    end
  end

  // Runs one pass from a quiescent state and checks its outcome against the model.
  task automatic run_pass(input logic [NSQ-1:0] dmask, input bit exp_err, input string tag);
    int n, exp_moves;
    build_expected();
    exp_moves = exp_q.size();
    done_mask = dmask;
    urst_cnt  = 0;
    rden_n    = 0;
    acc_n     = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_urst_start"}, unit_reset, 1);
    check({tag, "_err_clear"}, err, 0);
    check({tag, "_cnt_clear"}, move_count, 0);
    while (!gen_done && !err && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ended"}, gen_done || err, 1);
    check({tag, "_urst_cycles"}, urst_cnt, CLR_CYC);
    check({tag, "_busy_end"}, busy, 0);
    if (exp_err) begin
      check({tag, "_err"}, err, 1);
      check({tag, "_err_cycle"}, n, 1 + CLR_CYC + TIMEOUT);
      check({tag, "_gen_done"}, gen_done, 0);
      check({tag, "_no_rden"}, rden_n, 0);
    end else begin
      check({tag, "_gen_done"}, gen_done, 1);
      check({tag, "_err"}, err, 0);
      check({tag, "_accepted"}, acc_n, exp_moves);
      check({tag, "_move_count"}, move_count, (exp_moves > 255) ? 255 : exp_moves);
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_rden_count"}, rden_n, words_total);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [SLOT_BITS-1:0] w;
    int n;
    reset_n = 1'b1;
    start   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_unit_reset", unit_reset, 1);
    check("rst_rden", sq_rden, 0);
    check("rst_mv_valid", mv_valid, 0);
    check("rst_mv_data", mv_data, 0);
    check("rst_busy", busy, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_err", err, 0);
    check("rst_move_count", move_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_unit_reset", unit_reset, 0);
    check("idle_busy", busy, 0);
    clear_cells();

    // All cells empty.
    run_pass('1, 1'b0, "t1");

    // Cell 5: two valid slots among invalid ones.
    clear_cells();
    w = {SLOTS{IMOV}};
    w[7*MOVE_W +: MOVE_W] = 19'h0_0D15;
    w[2*MOVE_W +: MOVE_W] = 19'h0_0A0B;
    add_word(5, w);
    run_pass('1, 1'b0, "t2");

    // Multi-word cell drains before a higher cell.
    clear_cells();
    add_word(3, rand_word(100));
    add_word(3, rand_word(100));
    w = {SLOTS{IMOV}};
    w[4*MOVE_W +: MOVE_W] = {1'b0, 18'($urandom)};
    add_word(40, w);
    run_pass('1, 1'b0, "t3");

    // Back-pressure on the first move.
    clear_cells();
    w = {SLOTS{IMOV}};
    w[7*MOVE_W +: MOVE_W] = 19'h0_0D15;
    w[2*MOVE_W +: MOVE_W] = 19'h0_0A0B;
    add_word(5, w);
    stall_left = 4;
    run_pass('1, 1'b0, "t4");
    stall_left = 0;

    // Timeout on a missing done, then a clean rerun of the same cells.
    clear_cells();
    add_word(10, rand_word(60));
    run_pass({1'b0, {(NSQ-1){1'b1}}}, 1'b1, "t5");
    run_pass('1, 1'b0, "t5_rerun");

    // Random fills with random back-pressure.
    for (int p = 0; p < 5; p++) begin
      clear_cells();
      for (int k = 0; k < $urandom_range(8, 1); k++) begin
        int c = $urandom_range(NSQ - 1);
        for (int j = 0; j < $urandom_range(3, 1); j++) add_word(c, rand_word(50));
      end
      ready_pct = $urandom_range(100, 40);
      run_pass('1, 1'b0, "rand");
    end

    // More than 255 moves: move_count saturates.
    clear_cells();
    for (int c = 0; c < 40; c++) add_word(c, rand_word(100));
    ready_pct = 100;
    run_pass('1, 1'b0, "sat");

    // Reset in the middle of emission, then a clean pass.
    clear_cells();
    for (int c = 0; c < 6; c++) add_word(c * 9, rand_word(100));
    build_expected();
    done_mask = '1;
    ready_pct = 50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mv_valid && acc_n >= 3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_emit", mv_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_unit_reset", unit_reset, 1);
    check("t6_rden", sq_rden, 0);
    check("t6_mv_valid", mv_valid, 0);
    check("t6_mv_data", mv_data, 0);
    check("t6_busy", busy, 0);
    check("t6_gen_done", gen_done, 0);
    check("t6_err", err, 0);
    check("t6_move_count", move_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_cells();
    add_word(7, rand_word(70));
    add_word(50, rand_word(70));
    run_pass('1, 1'b0, "t6_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
